// File: rtl/sample_sched_pkg.sv
// sample_sched_pkg
//   Shared types and helpers for the per-triangle sample scheduler.
//   - state_t    : walker state (IDLE, ITER)
//   - step_shift : one-hot sample rate -> log2 of the sample step
//   - lane_log2  : log2 of the lane count, used to form the SAMPS*step group stride
package sample_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

  // The step is always a power of two, so it is kept as a shift amount.
  // Unrecognised codes fall back to one sample per pixel.
  function automatic int unsigned step_shift(input logic [3:0] sub, input int unsigned radix);
    case (sub)
      4'b0100: return radix - 1;
      4'b0010: return radix - 2;
      4'b0001: return radix - 3;
      default: return radix;
    endcase
  endfunction

  // Lane k sits at offset k << step_shift; a whole group spans
  // SAMPS << step_shift == 1 << (step_shift + lane_log2(SAMPS)).
  function automatic int unsigned lane_log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sample_lane_gen.sv
// sample_lane_gen
//   Combinational lane generator. For the current group origin (cur_x, cur_y)
//   it produces SAMPS horizontally adjacent sample positions spaced by the
//   step, and flags each lane valid when it does not pass the right box edge.
//   Ports:
//     cur_x, cur_y : group origin (signed, SIGFIG bits)
//     step_sh      : log2 of the sample step
//     box_x1       : right box edge (inclusive)
//     lane_x/lane_y: per-lane coordinates
//     lane_vld     : per-lane valid, bit k = lane k
module sample_lane_gen
  import sample_sched_pkg::*;
#(
  parameter int SIGFIG = 24,
  parameter int SAMPS  = 4,
  parameter int SHW    = 4
) (
  input  logic signed [SIGFIG-1:0] cur_x,
  input  logic signed [SIGFIG-1:0] cur_y,
  input  logic        [SHW-1:0]    step_sh,
  input  logic signed [SIGFIG-1:0] box_x1,
  output logic signed [SIGFIG-1:0] lane_x [SAMPS],
  output logic signed [SIGFIG-1:0] lane_y [SAMPS],
  output logic        [SAMPS-1:0]  lane_vld
);

  // One extra bit so a lane just past the largest coordinate cannot wrap
  // negative and slip under the edge compare.
  logic signed [SIGFIG:0] cur_x_ext;
  logic signed [SIGFIG:0] box_x1_ext;

  assign cur_x_ext  = {cur_x[SIGFIG-1], cur_x};
  assign box_x1_ext = {box_x1[SIGFIG-1], box_x1};

  for (genvar k = 0; k < SAMPS; k++) begin : g_lane
    logic signed [SIGFIG:0] off;
    logic signed [SIGFIG:0] sum;

    assign off         = (SIGFIG+1)'(k) << step_sh;
    assign sum         = cur_x_ext + off;
    assign lane_x[k]   = sum[SIGFIG-1:0];
    assign lane_y[k]   = cur_y;
    assign lane_vld[k] = (sum <= box_x1_ext);
  end

endmodule

// File: rtl/sample_sched.sv
// sample_sched
//   Walks a triangle's grid-aligned bounding box in raster order and issues
//   one group of SAMPS adjacent sample positions per unhalted cycle.
//   Ports:
//     clk, rst        : clock, asynchronous active-high reset
//     tri_R15S        : incoming triangle vertices
//     color_R15U      : incoming triangle color
//     box_R15S        : [0] = lower-left (x,y), [1] = upper-right (x,y)
//     subSample_R15U  : one-hot sample rate
//     validTri_R15H   : triangle present upstream
//     halt_R15H       : upstream stall (busy walking, or downstream halted)
//     halt_R16H       : downstream stall; freezes every R16 output
//     tri_R16S/color_R16U : copies of the accepted triangle
//     sample_R16S     : [0][k] lane x, [1][k] lane y
//     validSamp_R16H  : per-lane valid
//   Optional: define SAMPLE_SCHED_PERF_EN to add the saturating counters
//     perfTri_R16U, perfGrp_R16U and perfHalt_R16U.
module sample_sched
  import sample_sched_pkg::*;
#(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int SAMPS  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] tri_R15S   [VERTS][AXIS],
  input  logic        [SIGFIG-1:0] color_R15U [COLORS],
  input  logic signed [SIGFIG-1:0] box_R15S   [2][2],
  input  logic        [3:0]        subSample_R15U,
  input  logic                     validTri_R15H,
  output logic                     halt_R15H,
  input  logic                     halt_R16H,
  output logic signed [SIGFIG-1:0] tri_R16S    [VERTS][AXIS],
  output logic        [SIGFIG-1:0] color_R16U  [COLORS],
  output logic signed [SIGFIG-1:0] sample_R16S [2][SAMPS],
  output logic        [SAMPS-1:0]  validSamp_R16H
`ifdef SAMPLE_SCHED_PERF_EN
  ,
  output logic        [31:0]       perfTri_R16U,
  output logic        [31:0]       perfGrp_R16U,
  output logic        [31:0]       perfHalt_R16U
`endif
);

  localparam int LOG_S = lane_log2(SAMPS);
  localparam int SHW   = $clog2(RADIX + 2);

  state_t state_q, state_d;

  logic signed [SIGFIG-1:0] cur_x_q, cur_y_q;
  logic signed [SIGFIG-1:0] x0_q, x1_q, y1_q;
  logic                     inv_q;
  logic        [SHW-1:0]    step_sh_q;

  logic signed [SIGFIG-1:0] lane_x [SAMPS];
  logic signed [SIGFIG-1:0] lane_y [SAMPS];
  logic        [SAMPS-1:0]  lane_vld;

  logic                   accept, issue;
  logic signed [SIGFIG:0] grp_off, row_off;
  logic signed [SIGFIG:0] nx_sum, ny_sum;
  logic                   adv_x, adv_y, last;

  sample_lane_gen #(
    .SIGFIG (SIGFIG),
    .SAMPS  (SAMPS),
    .SHW    (SHW)
  ) u_lane_gen (
    .cur_x    (cur_x_q),
    .cur_y    (cur_y_q),
    .step_sh  (step_sh_q),
    .box_x1   (x1_q),
    .lane_x   (lane_x),
    .lane_y   (lane_y),
    .lane_vld (lane_vld)
  );

  assign accept = (state_q == IDLE) && validTri_R15H && !halt_R16H;
  assign issue  = (state_q == ITER) && !halt_R16H;

  // Advance decision in SIGFIG+1 bits so the stride never wraps before the compare.
  // An inverted box issues its single all-invalid group and stops there.
  assign grp_off = (SIGFIG+1)'(1) << (step_sh_q + LOG_S);
  assign row_off = (SIGFIG+1)'(1) << step_sh_q;
  assign nx_sum  = {cur_x_q[SIGFIG-1], cur_x_q} + grp_off;
  assign ny_sum  = {cur_y_q[SIGFIG-1], cur_y_q} + row_off;
  assign adv_x   = !inv_q && (nx_sum <= {x1_q[SIGFIG-1], x1_q});
  assign adv_y   = !inv_q && (ny_sum <= {y1_q[SIGFIG-1], y1_q});
  assign last    = !adv_x && !adv_y;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    halt_R15H = halt_R16H;
    case (state_q)
      IDLE: if (accept) state_d = ITER;
      ITER: begin
        halt_R15H = 1'b1;
        if (issue && last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the latched triangle, box and R16 outputs are ordinary flops, all
  // reset, so nothing stale reaches the sample test after a mid-walk reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VERTS; v++)
        for (int a = 0; a < AXIS; a++) tri_R16S[v][a] <= '0;
      for (int c = 0; c < COLORS; c++) color_R16U[c] <= '0;
      for (int k = 0; k < SAMPS; k++) begin
        sample_R16S[0][k] <= '0;
        sample_R16S[1][k] <= '0;
      end
      validSamp_R16H <= '0;
      cur_x_q        <= '0;
      cur_y_q        <= '0;
      x0_q           <= '0;
      x1_q           <= '0;
      y1_q           <= '0;
      inv_q          <= 1'b0;
      step_sh_q      <= '0;
    end else begin
      if (accept) begin
        tri_R16S   <= tri_R15S;
        color_R16U <= color_R15U;
        cur_x_q    <= box_R15S[0][0];
        cur_y_q    <= box_R15S[0][1];
        x0_q       <= box_R15S[0][0];
        x1_q       <= box_R15S[1][0];
        y1_q       <= box_R15S[1][1];
        inv_q      <= (box_R15S[1][0] < box_R15S[0][0]) ||
                      (box_R15S[1][1] < box_R15S[0][1]);
        step_sh_q  <= SHW'(step_shift(subSample_R15U, RADIX));
      end

      if (issue) begin
        for (int k = 0; k < SAMPS; k++) begin
          sample_R16S[0][k] <= lane_x[k];
          sample_R16S[1][k] <= lane_y[k];
        end
        validSamp_R16H <= lane_vld;
        if (adv_x) begin
          cur_x_q <= nx_sum[SIGFIG-1:0];
        end else if (adv_y) begin
          cur_x_q <= x0_q;
          cur_y_q <= ny_sum[SIGFIG-1:0];
        end
      end else if ((state_q == IDLE) && !halt_R16H) begin
        // Idle cycles present no samples; a halted idle cycle holds the last group.
        validSamp_R16H <= '0;
      end
    end
  end

`ifdef SAMPLE_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perfTri_R16U  <= '0;
      perfGrp_R16U  <= '0;
      perfHalt_R16U <= '0;
    end else begin
      if (accept && (perfTri_R16U != '1))
        perfTri_R16U <= perfTri_R16U + 32'd1;
      if (issue && (|lane_vld) && (perfGrp_R16U != '1))
        perfGrp_R16U <= perfGrp_R16U + 32'd1;
      if ((state_q == ITER) && halt_R16H && (perfHalt_R16U != '1))
        perfHalt_R16U <= perfHalt_R16U + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sample_sched.sv
// tb_sample_sched
//   Directed bench for sample_sched. Stimulus pushes hand-computed groups into
//   a scoreboard queue; a monitor compares every presented group on the
//   falling edge and retires it once downstream is not halting.
module tb_sample_sched;
  localparam int SIGFIG = 24;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;
  localparam int SAMPS  = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic signed [SIGFIG-1:0] tri_R15S    [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_R15U  [COLORS];
  logic signed [SIGFIG-1:0] box_R15S    [2][2];
  logic        [3:0]        subSample_R15U;
  logic                     validTri_R15H;
  logic                     halt_R15H;
  logic                     halt_R16H;
  logic signed [SIGFIG-1:0] tri_R16S    [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_R16U  [COLORS];
  logic signed [SIGFIG-1:0] sample_R16S [2][SAMPS];
  logic        [SAMPS-1:0]  validSamp_R16H;
`ifdef SAMPLE_SCHED_PERF_EN
  logic        [31:0]       perfTri_R16U, perfGrp_R16U, perfHalt_R16U;
`endif

  sample_sched dut (
    .clk            (clk),
    .rst            (rst),
    .tri_R15S       (tri_R15S),
    .color_R15U     (color_R15U),
    .box_R15S       (box_R15S),
    .subSample_R15U (subSample_R15U),
    .validTri_R15H  (validTri_R15H),
    .halt_R15H      (halt_R15H),
    .halt_R16H      (halt_R16H),
    .tri_R16S       (tri_R16S),
    .color_R16U     (color_R16U),
    .sample_R16S    (sample_R16S),
    .validSamp_R16H (validSamp_R16H)
`ifdef SAMPLE_SCHED_PERF_EN
    ,
    .perfTri_R16U   (perfTri_R16U),
    .perfGrp_R16U   (perfGrp_R16U),
    .perfHalt_R16U  (perfHalt_R16U)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SAMPS-1:0][SIGFIG-1:0] x;
    logic [SIGFIG-1:0]            y;
    logic [SAMPS-1:0]             vld;
    logic [SIGFIG-1:0]            tag;
  } grp_t;

  grp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int tag, input int y, input logic [3:0] vld,
                      input int x0, input int x1, input int x2, input int x3);
    grp_t e;
    e.x[0] = SIGFIG'(x0);
    e.x[1] = SIGFIG'(x1);
    e.x[2] = SIGFIG'(x2);
    e.x[3] = SIGFIG'(x3);
    e.y    = SIGFIG'(y);
    e.vld  = vld;
    e.tag  = SIGFIG'(tag);
    sb.push_back(e);
  endtask

  // Triangle payload is derived from a tag so the monitor can tell triangles apart.
  task automatic set_tri(input int tag, input int bx0, input int by0,
                         input int bx1, input int by1, input logic [3:0] sub);
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++) tri_R15S[v][a] = SIGFIG'(tag + v * AXIS + a);
    for (int c = 0; c < COLORS; c++) color_R15U[c] = SIGFIG'(tag + 100 + c);
    box_R15S[0][0] = SIGFIG'(bx0);
    box_R15S[0][1] = SIGFIG'(by0);
    box_R15S[1][0] = SIGFIG'(bx1);
    box_R15S[1][1] = SIGFIG'(by1);
    subSample_R15U = sub;
  endtask

  task automatic accept_tri(input int tag, input int bx0, input int by0,
                            input int bx1, input int by1, input logic [3:0] sub);
    set_tri(tag, bx0, by0, bx1, by1, sub);
    validTri_R15H = 1'b1;
    tick();
    validTri_R15H = 1'b0;
  endtask

  // Monitor: compare whatever group is on the outputs; retire it on an unhalted cycle.
  initial begin
    grp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (validSamp_R16H != '0)) begin
        if (sb.size() == 0) begin
          check("unexpected_group", sb.size(), 1);
        end else begin
          e = sb[0];
          for (int k = 0; k < SAMPS; k++) begin
            check($sformatf("lane%0d_x", k), sample_R16S[0][k], $signed(e.x[k]));
            check($sformatf("lane%0d_y", k), sample_R16S[1][k], $signed(e.y));
          end
          check("lane_vld", validSamp_R16H, e.vld);
          check("tri_tag", tri_R16S[0][0], $signed(e.tag));
          check("color_tag", color_R16U[COLORS-1], e.tag + 100 + COLORS - 1);
          if (!halt_R16H) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    halt_R16H     = 1'b1;
    validTri_R15H = 1'b0;
    set_tri(0, 0, 0, 0, 0, 4'b1000);

    // Reset state: upstream halt follows downstream, outputs cleared.
    #2;
    check("rst_halt_hi", halt_R15H, 1);
    halt_R16H = 1'b0;
    #1;
    check("rst_halt_lo", halt_R15H, 0);
    check("rst_vld", validSamp_R16H, 0);
    check("rst_x", sample_R16S[0][3], 0);
    check("rst_tri", tri_R16S[2][2], 0);
    tick();
    tick();
    rst = 1'b0;

    // Basic walk (0,0)-(5120,1024), downstream halted for 3 cycles after group 2.
    push(11, 0,    4'b1111, 0,    1024, 2048, 3072);
    push(11, 0,    4'b0011, 4096, 5120, 6144, 7168);
    push(11, 1024, 4'b1111, 0,    1024, 2048, 3072);
    push(11, 1024, 4'b0011, 4096, 5120, 6144, 7168);
    accept_tri(11, 0, 0, 5120, 1024, 4'b1000);
    check("walk_busy0", halt_R15H, 1);
    tick();
    tick();
    halt_R16H = 1'b1;
    repeat (3) begin
      tick();
      check("walk_hold_busy", halt_R15H, 1);
      check("walk_hold_x", sample_R16S[0][0], 4096);
    end
    halt_R16H = 1'b0;
    tick();
    check("walk_busy3", halt_R15H, 1);
    tick();
    check("walk_done", halt_R15H, 0);
    tick();
    check("walk_gap_vld", validSamp_R16H, 0);
    check("walk_drained", sb.size(), 0);
`ifdef SAMPLE_SCHED_PERF_EN
    check("perf_tri", perfTri_R16U, 1);
    check("perf_grp", perfGrp_R16U, 4);
    check("perf_halt", perfHalt_R16U, 3);
`endif

    // Degenerate box: one group, lane 0 only.
    push(12, 2048, 4'b0001, 2048, 3072, 4096, 5120);
    accept_tri(12, 2048, 2048, 2048, 2048, 4'b1000);
    tick();
    check("degen_done", halt_R15H, 0);
    tick();
    check("degen_gap", validSamp_R16H, 0);

    // Quarter step (256): two rows of four lanes.
    push(13, 0,   4'b1111, 0, 256, 512, 768);
    push(13, 256, 4'b1111, 0, 256, 512, 768);
    accept_tri(13, 0, 0, 768, 256, 4'b0010);
    tick();
    check("quarter_busy", halt_R15H, 1);
    tick();
    check("quarter_done", halt_R15H, 0);
    tick();

    // Illegal rate code falls back to step 1024.
    push(14, 0, 4'b0011, 0, 1024, 2048, 3072);
    accept_tri(14, 0, 0, 1024, 0, 4'b0110);
    tick();
    check("badcode_done", halt_R15H, 0);
    tick();

    // Inverted box: one all-invalid group, then idle (no row walk).
    accept_tri(15, 2048, 0, 1024, 4096, 4'b1000);
    tick();
    check("inv_vld", validSamp_R16H, 0);
    check("inv_done", halt_R15H, 0);
    tick();
    check("mid_drained", sb.size(), 0);

    // Back-to-back: second triangle waits upstream and enters after one gap cycle.
    push(21, 0,    4'b1111, 0,    1024, 2048, 3072);
    push(21, 0,    4'b0011, 4096, 5120, 6144, 7168);
    push(21, 1024, 4'b1111, 0,    1024, 2048, 3072);
    push(21, 1024, 4'b0011, 4096, 5120, 6144, 7168);
    push(22, 0,    4'b0011, -1024, 0, 1024, 2048);
    set_tri(21, 0, 0, 5120, 1024, 4'b1000);
    validTri_R15H = 1'b1;
    tick();
    set_tri(22, -1024, 0, 0, 0, 4'b1000);
    repeat (3) tick();
    check("b2b_busy", halt_R15H, 1);
    tick();
    check("b2b_idle", halt_R15H, 0);
    tick();
    validTri_R15H = 1'b0;
    check("b2b_gap_vld", validSamp_R16H, 0);
    check("b2b_gap_busy", halt_R15H, 1);
    check("b2b_tri_switch", tri_R16S[0][0], 22);
    tick();
    check("b2b_done", halt_R15H, 0);
    tick();
    check("b2b_drained", sb.size(), 0);

    // Reset while group 3 is on the outputs.
    push(31, 0, 4'b1111, 0,    1024, 2048, 3072);
    push(31, 0, 4'b0011, 4096, 5120, 6144, 7168);
    accept_tri(31, 0, 0, 5120, 1024, 4'b1000);
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rmid_vld", validSamp_R16H, 0);
    check("rmid_x", sample_R16S[0][0], 0);
    check("rmid_y", sample_R16S[1][0], 0);
    check("rmid_tri", tri_R16S[0][0], 0);
    check("rmid_color", color_R16U[0], 0);
    check("rmid_halt_lo", halt_R15H, 0);
    halt_R16H = 1'b1;
    #1;
    check("rmid_halt_hi", halt_R15H, 1);
`ifdef SAMPLE_SCHED_PERF_EN
    check("rmid_perf_tri", perfTri_R16U, 0);
`endif
    halt_R16H = 1'b0;
    tick();
    rst = 1'b0;
    check("rmid_drained", sb.size(), 0);

    push(32, 1024, 4'b0011, 3072, 4096, 5120, 6144);
    accept_tri(32, 3072, 1024, 4096, 1024, 4'b1000);
    tick();
    check("rnew_done", halt_R15H, 0);
    tick();
    check("final_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
